reg_dump_reader: RTL and testbench
==================================

# reg_dump_reader

Debug readout engine that reads the CPU's general-purpose register file and floating-point register file and streams the contents out over a valid/ready interface. The testbench and the host load path write instructions into the CPU. This block is the return path: a host or bench issues `start` and receives every selected register as a tagged 32-bit word. It sits beside the CPU and uses the register files' combinational read ports. It never writes CPU state.

## Interface
- `NUM_GPR`, default 32: GPR entries dumped, indices 0..NUM_GPR-1.
- `NUM_FPR`, default 32: FPR entries dumped, indices 0..NUM_FPR-1.
- `DATA_W`, default 32: register word width.
- `clk`  in  1: the single clock; all state changes on its rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `start`  in  1: begin a dump; sampled only in IDLE.
- `bank_sel`  in  2: sampled with `start`.
  - 01 = GPR only.
  - 10 = FPR only.
  - 11 = GPR then FPR.
  - 00 = empty dump.
- `abort`  in  1: terminate the dump in progress.
- `busy`  out  1: high in any state other than IDLE.
- `done`  out  1: one-cycle pulse when a dump completes normally.
- `gpr_raddr`  out  5: GPR read address, driven from the index register.
- `gpr_rdata`  in  DATA_W: combinational GPR read data.
- `fpr_raddr`  out  5: FPR read address, driven from the index register.
- `fpr_rdata`  in  DATA_W: combinational FPR read data.
- `out_valid`  out  1: `out_data`, `out_tag` and `out_last` are valid.
- `out_ready`  in  1: consumer accepts the word.
- `out_data`  out  DATA_W: captured register value.
- `out_tag`  out  6: bit5 = bank (0 GPR, 1 FPR); bits 4:0 = register index.
- `out_last`  out  1: high on the final word of the dump.

## Operation
- States: IDLE, FETCH, HOLD, DONE.
- IDLE:
  - On `start` with `bank_sel`≠00: latch `bank_sel`, set index=0, set bank to the first selected bank, go to FETCH.
  - On `start` with `bank_sel`=00: go directly to DONE.
  - `start` in any other state is ignored.
- FETCH:
  - `gpr_raddr` and `fpr_raddr` both equal the index.
  - Capture the selected bank's rdata into `out_data` and {bank, index} into `out_tag`.
  - Set `out_last` when index = (bank size - 1) and no further bank is selected.
  - Set `out_valid`=1 and go to HOLD.
- HOLD:
  - Hold all outputs stable until `out_valid && out_ready`.
  - On that handshake: clear `out_valid`.
    - If `out_last`: go to DONE.
    - Else if index = bank size - 1: index=0, bank=FPR, go to FETCH.
    - Else: index+1, go to FETCH.
- DONE: `done`=1 for this cycle only, then return to IDLE.
- `abort` has priority over every transition in FETCH, HOLD and DONE:
  - Next state is IDLE.
  - `out_valid` and `done` are low from the next cycle.
  - A word offered in the aborting cycle counts as not transferred.
  - Abort is the only case where `out_valid` falls without a handshake.
- Register contents are sampled at the FETCH edge. A CPU write to an already-dumped entry is not re-emitted.
- `out_data` and `out_tag` keep their last value while `out_valid`=0. Consumers must not rely on them.

## Timing
- Reset (`rst`=0, immediate):
  - State = IDLE.
  - `busy`, `done`, `out_valid`, `out_last` = 0.
  - `out_data` = 0, `out_tag` = 0.
  - Index and read addresses = 0.
- Reset asserted mid-dump discards the dump. No `done` is produced.
- Start latency: `start` at edge N gives FETCH in cycle N+1 and `out_valid`=1 from edge N+2.
- Throughput: with `out_ready` held high, one word every 2 cycles.
  - A 64-word dump (`bank_sel`=11) takes 128 cycles from the first FETCH to the last handshake.
  - `done` is high in the cycle after the last handshake.
  - `busy` falls one cycle after `done`.
- Empty dump: `start` at edge N gives `done` in cycle N+1. `out_valid` never rises.
- Back-pressure: `out_ready` low for K cycles in HOLD stretches that word by K cycles with no data change.
- `start` and `abort` together in IDLE: abort wins and the state stays IDLE.

## Test plan
- Preload GPR[k]=k\*3; `start`, `bank_sel`=01, `out_ready`=1 -> 32 words with tags 0x00..0x1F and data 0,3,...,93; `out_last` only on tag 0x1F; `done` one cycle after the last handshake.
- Preload FPR[1]=0x40214000, FPR[2]=0x4183D70A (16.48), FPR[3]=0x4197BD71; `bank_sel`=11 -> 64 words, GPRs first; tag 0x23 carries 0x4197BD71; `out_last` only on tag 0x3F.
- `out_ready` toggled pseudo-randomly -> `out_data`/`out_tag` never change while `out_valid`&&!`out_ready`; word order and count are identical to the ready-high run.
- `abort` while HOLD on tag 0x05 -> `out_valid`=0 and `busy`=0 next cycle; no `done`; a new `start` restarts at tag 0x00.
- Drop `rst` low mid-dump with `clk` stopped -> all outputs are at reset values immediately.
- `bank_sel`=00 -> `done` one cycle after `start` with no words; a second `start` issued while `busy` is ignored (word count unchanged).

Source files
------------

// File: rtl/reg_dump_reader.sv
// Debug readout engine: walks the GPR and/or FPR files through their combinational
// read ports and streams each entry out as a tagged word over valid/ready.
module reg_dump_reader #(
  parameter int NUM_GPR = 32,
  parameter int NUM_FPR = 32,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        bank_sel,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [4:0]        gpr_raddr,
  input  logic [DATA_W-1:0] gpr_rdata,
  output logic [4:0]        fpr_raddr,
  input  logic [DATA_W-1:0] fpr_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [5:0]        out_tag,
  output logic              out_last
);

  localparam logic [4:0] GPR_LAST = 5'(NUM_GPR - 1);
  localparam logic [4:0] FPR_LAST = 5'(NUM_FPR - 1);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DONE} state_t;

  state_t            state_reg;
  logic [4:0]        idx_reg;
  logic              bank_reg;      // 0 = GPR, 1 = FPR
  logic              also_fpr_reg;  // GPR pass is followed by an FPR pass
  logic              busy_reg;
  logic              done_reg;
  logic              out_valid_reg;
  logic              out_last_reg;
  logic [DATA_W-1:0] out_data_reg;
  logic [5:0]        out_tag_reg;
  logic              at_last;

  assign at_last = bank_reg ? (idx_reg == FPR_LAST) : (idx_reg == GPR_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      bank_reg      <= 1'b0;
      also_fpr_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      out_data_reg  <= '0;
      out_tag_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          // abort wins over a coincident start
          if (start && !abort) begin
            busy_reg <= 1'b1;
            if (bank_sel == 2'b00) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg    <= FETCH;
              idx_reg      <= '0;
              bank_reg     <= ~bank_sel[0];
              also_fpr_reg <= bank_sel[0] & bank_sel[1];
            end
          end
        end

        FETCH: begin
          if (abort) begin
            state_reg     <= IDLE;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
          end else begin
            out_data_reg  <= bank_reg ? fpr_rdata : gpr_rdata;
            out_tag_reg   <= {bank_reg, idx_reg};
            out_last_reg  <= at_last && (bank_reg || !also_fpr_reg);
            out_valid_reg <= 1'b1;
            state_reg     <= HOLD;
          end
        end

        HOLD: begin
          if (abort) begin
            state_reg     <= IDLE;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
          end else if (out_valid_reg && out_ready) begin
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            if (out_last_reg) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end else if (at_last) begin
              idx_reg   <= '0;
              bank_reg  <= 1'b1;
              state_reg <= FETCH;
            end else begin
              idx_reg   <= idx_reg + 5'd1;
              state_reg <= FETCH;
            end
          end
        end

        DONE: begin
          state_reg     <= IDLE;
          busy_reg      <= 1'b0;
          done_reg      <= 1'b0;
          out_valid_reg <= 1'b0;
        end

        default: begin
          state_reg     <= IDLE;
          busy_reg      <= 1'b0;
          done_reg      <= 1'b0;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign gpr_raddr = idx_reg;
  assign fpr_raddr = idx_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_tag   = out_tag_reg;
  assign out_last  = out_last_reg;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Self-checking bench for reg_dump_reader: table of dump configurations plus
// hand-written abort, reset-with-stopped-clock and ignored-start sequences.
module tb_reg_dump_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  bank_sel = 2'b00;
  logic        abort = 1'b0;
  logic        out_ready = 1'b0;
  logic        busy, done, out_valid, out_last;
  logic [4:0]  gpr_raddr, fpr_raddr;
  logic [31:0] gpr_rdata, fpr_rdata, out_data;
  logic [5:0]  out_tag;

  logic [31:0] gpr_mem [32];
  logic [31:0] fpr_mem [32];

  assign gpr_rdata = gpr_mem[gpr_raddr];
  assign fpr_rdata = fpr_mem[fpr_raddr];

  bit clk_run = 1'b1;
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  reg_dump_reader #(.NUM_GPR(32), .NUM_FPR(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .bank_sel(bank_sel), .abort(abort),
    .busy(busy), .done(done),
    .gpr_raddr(gpr_raddr), .gpr_rdata(gpr_rdata),
    .fpr_raddr(fpr_raddr), .fpr_rdata(fpr_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .out_last(out_last)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] sel;
    int         n_words;
    logic       rand_ready;
    int         done_cyc;   // negedge index (1 = cycle after start) where done is seen
    logic [5:0] last_tag;
  } vec_t;

  vec_t vecs [5];

  task automatic do_dump(input vec_t v);
    logic [5:0]  exp_tag [$];
    logic [31:0] exp_data [$];
    int          k, j, last_hs, first_valid;
    bit          got_done, stalled;
    logic [31:0] held_d, d23;
    logic [5:0]  held_t, last_seen;
    k = 0; j = 1; last_hs = -1; first_valid = -1;
    got_done = 0; stalled = 0; d23 = '0; last_seen = '0; held_d = '0; held_t = '0;
    if (v.sel[0]) for (int i = 0; i < 32; i++) begin
      exp_tag.push_back({1'b0, 5'(i)});
      exp_data.push_back(gpr_mem[i]);
    end
    if (v.sel[1]) for (int i = 0; i < 32; i++) begin
      exp_tag.push_back({1'b1, 5'(i)});
      exp_data.push_back(fpr_mem[i]);
    end

    @(negedge clk);
    start = 1'b1;
    bank_sel = v.sel;
    @(negedge clk);
    start = 1'b0;
    bank_sel = 2'b10;
    chk("busy_after_start", 32'(busy), 32'd1);
    while (!got_done && j < 2000) begin
      if (stalled) begin
        chk("valid_held_in_stall", 32'(out_valid), 32'd1);
        chk("data_stable_in_stall", out_data, held_d);
        chk("tag_stable_in_stall", 32'(out_tag), 32'(held_t));
      end
      stalled = 0;
      // a start issued mid-dump must be ignored
      start = (j == 10) && (v.n_words > 0);
      if (done) begin
        got_done = 1;
        chk("word_count", 32'(k), 32'(v.n_words));
        if (!v.rand_ready) chk("done_cycle", 32'(j), 32'(v.done_cyc));
        else               chk("done_after_last_hs", 32'(j), 32'(last_hs + 1));
      end else if (out_valid) begin
        if (first_valid < 0) begin
          first_valid = j;
          chk("first_valid_latency", 32'(j), 32'd2);
        end
        out_ready = v.rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (out_ready) begin
          if (k < exp_tag.size()) begin
            chk("word_tag", 32'(out_tag), 32'(exp_tag[k]));
            chk("word_data", out_data, exp_data[k]);
            chk("word_last", 32'(out_last), 32'(k == exp_tag.size() - 1));
          end else begin
            chk("extra_word", 32'(k), 32'(exp_tag.size()));
          end
          $display("xfer sel=%b n=%0d tag=%h data=%h last=%b", v.sel, k, out_tag, out_data, out_last);
          if (out_tag == 6'h23) d23 = out_data;
          last_seen = out_tag;
          k++;
          last_hs = j;
        end else begin
          stalled = 1;
          held_d = out_data;
          held_t = out_tag;
        end
      end
      @(negedge clk);
      j++;
    end
    start = 1'b0;
    chk("done_seen", 32'(got_done), 32'd1);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("busy_after_done", 32'(busy), 32'd0);
    if (v.n_words > 0) chk("last_tag", 32'(last_seen), 32'(v.last_tag));
    if (v.sel == 2'b11) chk("tag23_data", d23, 32'h4197BD71);
    out_ready = 1'b0;
  endtask

  initial begin
    int n;
    bit found;
    for (int i = 0; i < 32; i++) begin
      gpr_mem[i] = 32'(i * 3);
      fpr_mem[i] = 32'hC0DE0000 + 32'(i);
    end
    fpr_mem[1] = 32'h40214000;
    fpr_mem[2] = 32'h4183D70A;
    fpr_mem[3] = 32'h4197BD71;

    vecs[0] = '{sel: 2'b01, n_words: 32, rand_ready: 1'b0, done_cyc: 65,  last_tag: 6'h1F};
    vecs[1] = '{sel: 2'b10, n_words: 32, rand_ready: 1'b0, done_cyc: 65,  last_tag: 6'h3F};
    vecs[2] = '{sel: 2'b11, n_words: 64, rand_ready: 1'b0, done_cyc: 129, last_tag: 6'h3F};
    vecs[3] = '{sel: 2'b00, n_words: 0,  rand_ready: 1'b0, done_cyc: 1,   last_tag: 6'h00};
    vecs[4] = '{sel: 2'b11, n_words: 64, rand_ready: 1'b1, done_cyc: 0,   last_tag: 6'h3F};

    // reset state
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_tag", 32'(out_tag), 32'd0);
    chk("rst_raddr", 32'({gpr_raddr, fpr_raddr}), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int t = 0; t < 5; t++) begin
      do_dump(vecs[t]);
      $display("dump %0d sel=%b done", t, vecs[t].sel);
    end

    // start together with abort in IDLE: stays idle
    @(negedge clk);
    start = 1'b1; abort = 1'b1; bank_sel = 2'b01;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("start_abort_valid", 32'(out_valid), 32'd0);
    $display("start+abort in idle");

    // abort while holding tag 0x05
    @(negedge clk);
    start = 1'b1; bank_sel = 2'b01;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (out_valid && out_tag == 6'h05) found = 1;
      else begin
        out_ready = 1'b1;
        @(negedge clk);
      end
    end
    chk("abort_target_found", 32'(found), 32'd1);
    out_ready = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    n = 0;
    repeat (4) begin
      @(negedge clk);
      if (done || out_valid) n++;
    end
    chk("abort_no_done_later", 32'(n), 32'd0);
    $display("abort at tag 05");
    do_dump(vecs[0]);

    // empty dump; second start while busy in DONE is ignored
    @(negedge clk);
    start = 1'b1; bank_sel = 2'b00;
    @(negedge clk);
    chk("empty_done", 32'(done), 32'd1);
    start = 1'b1; bank_sel = 2'b01;
    @(negedge clk);
    start = 1'b0;
    chk("empty_busy_after", 32'(busy), 32'd0);
    n = 0;
    repeat (5) begin
      if (out_valid) n++;
      @(negedge clk);
    end
    chk("ignored_start_words", 32'(n), 32'd0);
    $display("empty dump with ignored start");

    // reset asserted with the clock stopped mid-dump
    @(negedge clk);
    start = 1'b1; bank_sel = 2'b11;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (out_valid && out_tag == 6'h08) found = 1;
      else begin
        out_ready = 1'b1;
        @(negedge clk);
      end
    end
    chk("rst_target_found", 32'(found), 32'd1);
    clk_run = 1'b0;
    out_ready = 1'b0;
    #20;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    rst = 1'b0;
    #1;
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_done", 32'(done), 32'd0);
    chk("async_valid", 32'(out_valid), 32'd0);
    chk("async_last", 32'(out_last), 32'd0);
    chk("async_data", out_data, 32'd0);
    chk("async_tag", 32'(out_tag), 32'd0);
    chk("async_raddr", 32'({gpr_raddr, fpr_raddr}), 32'd0);
    #10;
    rst = 1'b1;
    #3;
    clk_run = 1'b1;
    n = 0;
    repeat (5) begin
      @(negedge clk);
      if (done || busy) n++;
    end
    chk("post_rst_idle", 32'(n), 32'd0);
    $display("async reset mid-dump");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
